csr_exec_unit: RTL and testbench

- Execute-stage sequencer for Zicsr and trap instructions: CSRRW/CSRRS/CSRRC (register and immediate forms), ECALL and MRET.
- Sits between the EXU decode/operand path and the machine CSR register file. It drives that file's single read/write index and write port, and pulses its exception input.
- Produces the rd writeback value and a one-cycle PC redirect for trap entry and return.
- Accepts one instruction at a time under valid/ready handshakes.

---
 rtl/csr_exec_unit_if.sv | 51 +++++
 rtl/csr_exec_unit.sv | 172 +++++++++++++++++
 tb/tb_csr_exec_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_exec_unit_if.sv
// csr_exec_unit_if: groups the instruction handshake, CSR file port, trap/redirect
// and writeback signals of csr_exec_unit.
// Handshake rule: a transfer happens on a rising clk edge where valid and ready are
// both high; valid may not depend on ready, and payload is held while valid waits.
// master = the surrounding pipeline/CSR file, slave = csr_exec_unit.
interface csr_exec_unit_if #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic              in_use_imm;
    logic [XLEN-1:0]   in_rs1;
    logic [4:0]        in_zimm;
    logic [CSR_AW-1:0] in_csr_addr;
    logic [XLEN-1:0]   in_pc;
    logic [CSR_AW-1:0] csr_idx;
    logic              csr_wr_en;
    logic [XLEN-1:0]   csr_wr_data;
    logic [XLEN-1:0]   csr_rd_data;
    logic [XLEN-1:0]   csr_mtvec;
    logic              exception;
    logic [XLEN-1:0]   exc_pc;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic              out_rd_we;
    logic [XLEN-1:0]   out_rd_data;

    modport master (
        output in_valid, in_op, in_use_imm, in_rs1, in_zimm, in_csr_addr, in_pc,
        input  in_ready,
        input  csr_idx, csr_wr_en, csr_wr_data,
        output csr_rd_data, csr_mtvec,
        input  exception, exc_pc, redirect_valid, redirect_pc,
        input  out_valid, out_rd_we, out_rd_data,
        output out_ready
    );

    modport slave (
        input  in_valid, in_op, in_use_imm, in_rs1, in_zimm, in_csr_addr, in_pc,
        output in_ready,
        output csr_idx, csr_wr_en, csr_wr_data,
        input  csr_rd_data, csr_mtvec,
        output exception, exc_pc, redirect_valid, redirect_pc,
        output out_valid, out_rd_we, out_rd_data,
        input  out_ready
    );
endinterface

// File: rtl/csr_exec_unit.sv
// csr_exec_unit: execute-stage sequencer for CSRRW/CSRRS/CSRRC (reg/imm), ECALL, MRET.
// Flow: IDLE -> EXEC -> (REDIR) -> DONE -> IDLE. The CSR file port (index, write,
// exception) is decoded from the EXEC state so the read-modify-write sees this
// cycle's combinational csr_rd_data; all other outputs are registered.
// Optional build macro: CSR_ILLEGAL_CHK_EN turns unknown CSR addresses and writes to
// the read-only range into an illegal-instruction trap (mcause 2).
module csr_exec_unit #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    csr_exec_unit_if.slave        bus,
    output logic [1:0]            o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_REDIR, S_DONE} state_t;

    localparam logic [2:0] OP_RW = 3'd1, OP_RS = 3'd2, OP_RC = 3'd3, OP_ECALL = 3'd4, OP_MRET = 3'd5;
    localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(12'h305);
    localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);

    state_t            r_state;
    logic [2:0]        r_op;
    logic              r_use_imm;
    logic [XLEN-1:0]   r_rs1;
    logic [4:0]        r_zimm;
    logic [CSR_AW-1:0] r_addr;
    logic [XLEN-1:0]   r_pc;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_out_rd_we;
    logic [XLEN-1:0]   r_out_rd_data;
    logic              r_redir_valid;
    logic [XLEN-1:0]   r_redir_pc;

    logic [XLEN-1:0]   w_src;
    logic              w_is_csr;
    logic              w_wr_attempt;
    logic              w_illegal;
    logic              w_trap;
    logic [CSR_AW-1:0] w_idx;
    logic              w_wr_en;
    logic [XLEN-1:0]   w_wr_data;
    logic              w_exc;
    logic [XLEN-1:0]   w_exc_pc;
    logic [XLEN-1:0]   w_target;

    assign w_src        = r_use_imm ? {{(XLEN-5){1'b0}}, r_zimm} : r_rs1;
    assign w_is_csr     = (r_op == OP_RW) || (r_op == OP_RS) || (r_op == OP_RC);
    // The zimm/rs1-index field decides whether a set/clear writes, for both forms.
    assign w_wr_attempt = (r_op == OP_RW) || (r_zimm != 5'd0);

`ifdef CSR_ILLEGAL_CHK_EN
    assign w_illegal = w_is_csr &&
                       (!((r_addr == A_MSTATUS) || (r_addr == A_MTVEC) ||
                          (r_addr == A_MEPC)    || (r_addr == A_MCAUSE)) ||
                        ((r_addr[CSR_AW-1 -: 2] == 2'b11) && w_wr_attempt));
`else
    assign w_illegal = 1'b0;
`endif

    assign w_trap = (r_op == OP_ECALL) || w_illegal;

    // CSR file port: active only in EXEC; reset in the same cycle suppresses the side effects.
    always_comb begin
        w_idx     = '0;
        w_wr_en   = 1'b0;
        w_wr_data = '0;
        w_exc     = 1'b0;
        w_exc_pc  = '0;
        w_target  = '0;
        if (r_state == S_EXEC) begin
            if (w_trap) begin
                w_idx     = A_MCAUSE;
                w_wr_en   = rst_n;
                w_wr_data = w_illegal ? XLEN'(2) : XLEN'(11);
                w_exc     = rst_n;
                w_exc_pc  = r_pc;
                w_target  = bus.csr_mtvec;
            end else if (r_op == OP_MRET) begin
                w_idx    = A_MEPC;
                w_target = bus.csr_rd_data;
            end else if (w_is_csr) begin
                w_idx   = r_addr;
                w_wr_en = rst_n && w_wr_attempt;
                case (r_op)
                    OP_RS:   w_wr_data = bus.csr_rd_data | w_src;
                    OP_RC:   w_wr_data = bus.csr_rd_data & ~w_src;
                    default: w_wr_data = w_src;
                endcase
            end
        end
    end

    // Sequencer: accept, execute, optional redirect, hold result until writeback takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_use_imm     <= 1'b0;
            r_rs1         <= '0;
            r_zimm        <= '0;
            r_addr        <= '0;
            r_pc          <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_rd_we   <= 1'b0;
            r_out_rd_data <= '0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= bus.in_op;
                        r_use_imm  <= bus.in_use_imm;
                        r_rs1      <= bus.in_rs1;
                        r_zimm     <= bus.in_zimm;
                        r_addr     <= bus.in_csr_addr;
                        r_pc       <= bus.in_pc;
                        r_in_ready <= 1'b0;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_trap || (r_op == OP_MRET)) begin
                        r_redir_valid <= 1'b1;
                        r_redir_pc    <= w_target;
                        r_state       <= S_REDIR;
                    end else begin
                        r_out_valid   <= 1'b1;
                        r_out_rd_we   <= w_is_csr;
                        r_out_rd_data <= w_is_csr ? bus.csr_rd_data : '0;
                        r_state       <= S_DONE;
                    end
                end
                S_REDIR: begin
                    r_redir_valid <= 1'b0;
                    r_redir_pc    <= '0;
                    r_out_valid   <= 1'b1;
                    r_out_rd_we   <= 1'b0;
                    r_out_rd_data <= '0;
                    r_state       <= S_DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        r_out_valid   <= 1'b0;
                        r_out_rd_we   <= 1'b0;
                        r_out_rd_data <= '0;
                        r_in_ready    <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.csr_idx        = w_idx;
    assign bus.csr_wr_en      = w_wr_en;
    assign bus.csr_wr_data    = w_wr_data;
    assign bus.exception      = w_exc;
    assign bus.exc_pc         = w_exc_pc;
    assign bus.redirect_valid = r_redir_valid;
    assign bus.redirect_pc    = r_redir_pc;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_rd_we      = r_out_rd_we;
    assign bus.out_rd_data    = r_out_rd_data;
    assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_csr_exec_unit.sv
// tb_csr_exec_unit: directed and randomized stimulus for csr_exec_unit against a
// per-transaction reference model; a CSR register file lives in the bench.
module tb_csr_exec_unit;
  localparam int XLEN = 64;
  localparam int AW   = 12;

  typedef struct packed {
    logic            in_ready;
    logic            is_done;
    logic            out_valid;
    logic            rd_we;
    logic [XLEN-1:0] rd_data;
    logic            wr_en;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] wr_data;
    logic            exc;
    logic [XLEN-1:0] exc_pc;
    logic            redir;
    logic [XLEN-1:0] redir_pc;
  } cyc_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic checking = 1'b0;
  always #5 clk = ~clk;

  csr_exec_unit_if #(.XLEN(XLEN), .CSR_AW(AW)) bus ();
  logic [1:0] dbg_state;

  csr_exec_unit #(.XLEN(XLEN), .CSR_AW(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- CSR file environment ----------------
  logic [XLEN-1:0] csr_file [0:4095] = '{default: '0};
  logic            preset_en = 1'b0;
  logic [AW-1:0]   preset_addr = '0;
  logic [XLEN-1:0] preset_val = '0;

  assign bus.csr_rd_data = csr_file[bus.csr_idx];
  assign bus.csr_mtvec   = csr_file[12'h305];

  always @(posedge clk) begin
    if (preset_en) csr_file[preset_addr] <= preset_val;
    if (bus.csr_wr_en) csr_file[bus.csr_idx] <= bus.csr_wr_data;
    if (bus.exception) csr_file[12'h341] <= bus.exc_pc;
  end

  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int redir_cnt = 0;
  logic [XLEN-1:0] last_rd_data = '0;
  logic [XLEN-1:0] last_redir_pc = '0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t idle_rec();
    cyc_t r;
    r = '0;
    r.in_ready = 1'b1;
    return r;
  endfunction

  cyc_t exp_q[$];
  cyc_t cur = idle_rec();

  // Spec-level result of one instruction: list of per-cycle expected outputs.
  task automatic model_accept(input logic [2:0] op, input logic use_imm, input logic [XLEN-1:0] rs1,
                              input logic [4:0] zimm, input logic [AW-1:0] addr, input logic [XLEN-1:0] pc);
    cyc_t ex, rd, dn;
    logic [XLEN-1:0] old, src;
    logic is_csr, illegal;
    old = csr_file[addr];
    src = use_imm ? {{(XLEN-5){1'b0}}, zimm} : rs1;
    ex = '0;
    rd = '0;
    dn = '0;
    dn.out_valid = 1'b1;
    dn.is_done = 1'b1;
    rd.redir = 1'b1;
    is_csr = (op >= 3'd1) && (op <= 3'd3);
    illegal = 1'b0;
`ifdef CSR_ILLEGAL_CHK_EN
    illegal = is_csr && (!(addr inside {12'h300, 12'h305, 12'h341, 12'h342}) ||
                         (addr >= 12'hC00 && (op == 3'd1 || zimm != 0)));
`endif
    if (illegal || op == 3'd4) begin
      ex.wr_en = 1'b1;
      ex.idx = 12'h342;
      ex.wr_data = (op == 3'd4) ? 64'd11 : 64'd2;
      ex.exc = 1'b1;
      ex.exc_pc = pc;
      rd.redir_pc = csr_file[12'h305];
      exp_q.push_back(ex);
      exp_q.push_back(rd);
    end else if (op == 3'd5) begin
      rd.redir_pc = csr_file[12'h341];
      exp_q.push_back(ex);
      exp_q.push_back(rd);
    end else if (is_csr) begin
      ex.wr_en = (op == 3'd1) || (zimm != 0);
      ex.idx = addr;
      ex.wr_data = (op == 3'd1) ? src : (op == 3'd2) ? (old | src) : (old & ~src);
      dn.rd_we = 1'b1;
      dn.rd_data = old;
      exp_q.push_back(ex);
    end else begin
      exp_q.push_back(ex);
    end
    exp_q.push_back(dn);
  endtask

  // Compare every cycle, then advance the model using the inputs the next edge will see.
  always @(negedge clk) begin
    if (checking) begin
      chk("in_ready", 64'(bus.in_ready), 64'(cur.in_ready));
      chk("out_valid", 64'(bus.out_valid), 64'(cur.out_valid));
      chk("out_rd_we", 64'(bus.out_rd_we), 64'(cur.rd_we));
      if (cur.out_valid) chk("out_rd_data", bus.out_rd_data, cur.rd_data);
      chk("csr_wr_en", 64'(bus.csr_wr_en), 64'(cur.wr_en && rst_n));
      if (cur.wr_en && rst_n) begin
        chk("csr_idx", 64'(bus.csr_idx), 64'(cur.idx));
        chk("csr_wr_data", bus.csr_wr_data, cur.wr_data);
      end
      chk("exception", 64'(bus.exception), 64'(cur.exc && rst_n));
      if (cur.exc && rst_n) chk("exc_pc", bus.exc_pc, cur.exc_pc);
      chk("redirect_valid", 64'(bus.redirect_valid), 64'(cur.redir));
      if (cur.redir) chk("redirect_pc", bus.redirect_pc, cur.redir_pc);
      if (bus.out_valid && bus.out_ready) last_rd_data = bus.out_rd_data;
      if (bus.redirect_valid) begin
        redir_cnt++;
        last_redir_pc = bus.redirect_pc;
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      cur = idle_rec();
    end else if (cur.in_ready) begin
      if (bus.in_valid) begin
        model_accept(bus.in_op, bus.in_use_imm, bus.in_rs1, bus.in_zimm, bus.in_csr_addr, bus.in_pc);
        cur = exp_q.pop_front();
      end
    end else if (cur.is_done) begin
      if (bus.out_ready) cur = idle_rec();
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else begin
      cur = idle_rec();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble();
    bus.in_op = 3'($urandom_range(0, 7));
    bus.in_use_imm = 1'($urandom_range(0, 1));
    bus.in_rs1 = {$urandom, $urandom};
    bus.in_zimm = 5'($urandom_range(0, 31));
    bus.in_csr_addr = 12'($urandom_range(0, 4095));
    bus.in_pc = {$urandom, $urandom};
  endtask

  task automatic preset(input logic [AW-1:0] a, input logic [XLEN-1:0] v);
    preset_addr = a;
    preset_val = v;
    preset_en = 1'b1;
    @(posedge clk);
    #1;
    preset_en = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic use_imm, input logic [XLEN-1:0] rs1,
                      input logic [4:0] zimm, input logic [AW-1:0] addr, input logic [XLEN-1:0] pc);
    int t;
    logic acc;
    t = 0;
    acc = 1'b0;
    bus.in_op = op;
    bus.in_use_imm = use_imm;
    bus.in_rs1 = rs1;
    bus.in_zimm = zimm;
    bus.in_csr_addr = addr;
    bus.in_pc = pc;
    bus.in_valid = 1'b1;
    while (!acc && t < 60) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    scramble();
    n_checks++;
    if (!acc) begin
      n_errors++;
      $display("FAIL accept_timeout: not accepted after %0d cycles, required acceptance", t);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 60);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int rc0;
    logic [2:0] ops [10] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0, 3'd6};
    logic [AW-1:0] addrs [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0, 12'hC00};
    bus.in_valid = 1'b0;
    scramble();
    @(posedge clk);
    #1;
    checking = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // CSRRW 0x305 <- 0x8000_0100, old 0
    preset(12'h305, 64'h0);
    send(3'd1, 1'b0, 64'h8000_0100, 5'd3, 12'h305, 64'h8000_0000);
    wait_idle(lat);
    chk("csrrw_latency", 64'(lat), 64'd3);
    chk("csrrw_written", csr_file[12'h305], 64'h8000_0100);
    chk("csrrw_rd_old", last_rd_data, 64'h0);

    // CSRRS zimm=0: read only
    preset(12'h341, 64'h8000_0004);
    send(3'd2, 1'b1, 64'hFFFF, 5'd0, 12'h341, 64'h8000_0004);
    wait_idle(lat);
    chk("csrrs_rd", last_rd_data, 64'h8000_0004);
    chk("csrrs_no_write", csr_file[12'h341], 64'h8000_0004);

    // CSRRC rs1=0xF, old 0xFF
    preset(12'h300, 64'hFF);
    send(3'd3, 1'b0, 64'hF, 5'd1, 12'h300, 64'h8000_0008);
    wait_idle(lat);
    chk("csrrc_result", csr_file[12'h300], 64'hF0);
    chk("csrrc_rd", last_rd_data, 64'hFF);

    // ECALL
    preset(12'h305, 64'h8000_1000);
    rc0 = redir_cnt;
    send(3'd4, 1'b0, 64'h0, 5'd0, 12'h000, 64'h8000_0010);
    wait_idle(lat);
    chk("ecall_latency", 64'(lat), 64'd4);
    chk("ecall_mcause", csr_file[12'h342], 64'd11);
    chk("ecall_mepc", csr_file[12'h341], 64'h8000_0010);
    chk("ecall_target", last_redir_pc, 64'h8000_1000);
    chk("ecall_redir_cycles", 64'(redir_cnt - rc0), 64'd1);

    // MRET
    preset(12'h341, 64'h8000_0014);
    rc0 = redir_cnt;
    send(3'd5, 1'b0, 64'h0, 5'd0, 12'h000, 64'h8000_1040);
    wait_idle(lat);
    chk("mret_target", last_redir_pc, 64'h8000_0014);
    chk("mret_redir_cycles", 64'(redir_cnt - rc0), 64'd1);

    // Writeback stall: second instruction offered while the first is held in DONE
    preset(12'h300, 64'h1234);
    ready_mode = 2;
    send(3'd2, 1'b1, 64'h0, 5'd0, 12'h300, 64'h8000_0020);
    fork
      send(3'd1, 1'b0, 64'hAA, 5'd2, 12'h300, 64'h8000_0024);
      begin
        repeat (7) @(negedge clk);
        ready_mode = 0;
      end
    join
    wait_idle(lat);
    chk("stall_second_rd", last_rd_data, 64'h1234);
    chk("stall_second_write", csr_file[12'h300], 64'hAA);

    // Reset during EXEC of ECALL
    preset(12'h342, 64'h0);
    rc0 = redir_cnt;
    send(3'd4, 1'b0, 64'h0, 5'd0, 12'h000, 64'h8000_0030);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_abort_no_redir", 64'(redir_cnt - rc0), 64'd0);
    chk("rst_abort_no_mcause", csr_file[12'h342], 64'h0);
    @(posedge clk);
    #1;

    // Reserved ops
    send(3'd0, 1'b0, 64'h5, 5'd5, 12'h300, 64'h0);
    wait_idle(lat);
    chk("reserved0_latency", 64'(lat), 64'd3);
    send(3'd7, 1'b0, 64'h5, 5'd5, 12'h300, 64'h0);
    wait_idle(lat);
    chk("reserved7_latency", 64'(lat), 64'd3);

`ifdef CSR_ILLEGAL_CHK_EN
    preset(12'h7C0, 64'h77);
    rc0 = redir_cnt;
    send(3'd1, 1'b0, 64'h1, 5'd1, 12'h7C0, 64'h8000_0040);
    wait_idle(lat);
    chk("illegal_mcause", csr_file[12'h342], 64'd2);
    chk("illegal_no_write", csr_file[12'h7C0], 64'h77);
    chk("illegal_redir", 64'(redir_cnt - rc0), 64'd1);
`endif

    // Randomized traffic with random writeback backpressure
    ready_mode = 1;
    repeat (300) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        scramble();
        @(posedge clk);
        #1;
      end
      send(ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)), {$urandom, $urandom},
           5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
           addrs[$urandom_range(0, 5)], {$urandom, $urandom});
    end
    ready_mode = 0;
    wait_idle(lat);
    chk("final_idle", 64'(bus.in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
